memory_stage: RTL
=================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have parameter D_WIDTH, default 32, datapath width.
REQ-002 SHALL have parameter A_WIDTH, default 5, register-address width.
REQ-003 SHALL have parameter DM_DEPTH, default 1024, data-memory depth in D_WIDTH words (power of two).
REQ-004 SHALL have ports: clk input 1, the single clock; rst_n input 1, reset, synchronous, active-low.
REQ-005 SHALL have ports: RegWriteE, MemWriteE, ATypeE, FlushM input 1 each; ResultSrcE input 2; ALUResultE, WriteDataE, PCplus4E input D_WIDTH; RdE input A_WIDTH.
REQ-006 SHALL have outputs: RegWriteM 1, RdM A_WIDTH, ALUResultM D_WIDTH; these are the forwarding feedback to Execute.
REQ-007 SHALL have outputs: RegWriteW 1, RdW A_WIDTH, ResultW D_WIDTH; this is the writeback result and the forwarding source.

Function
REQ-008 SHALL register all E inputs into M registers at each rising clk; E data presented before edge k appears on M outputs after edge k.
REQ-009 SHALL register M-stage RegWrite, ResultSrc, Rd, ALUResult, PCplus4 and memory read data into W registers at each rising clk, giving total E-to-W latency of 2 edges.
REQ-010 SHALL, when FlushM=1 at an edge, load RegWriteM=0 and MemWriteM=0 instead of the E values; data fields load normally.
REQ-011 SHALL hold DM_DEPTH words; word index = ALUResultM[log2(DM_DEPTH)+1:2]; upper address bits ignored (wrap modulo DM_DEPTH*4 bytes).
REQ-012 SHALL read combinationally from the M-stage address and write synchronously at the edge ending the cycle in which MemWriteM=1.
REQ-013 SHALL, for word access (ATypeM=0), ignore address bits [1:0] on both read and write.
REQ-014 SHALL make a load in the cycle after a store to the same address return the stored data.
REQ-015 SHALL drive ResultW combinationally from W registers: ResultSrcW 00 ALUResultW, 01 ReadDataW, 10 PCplus4W, 11 zero.
REQ-016 SHALL not consume MemWrite or RegWrite from a bubble; no stall input exists, so the stage advances every cycle.

Reset
REQ-017 SHALL, on an edge with rst_n=0, clear all M and W registers to zero; consequently RegWriteM, RdM, ALUResultM, RegWriteW, RdW and ResultW are 0 after reset.
REQ-018 SHALL suppress any memory write on an edge where rst_n=0, including a store in flight.
REQ-019 SHALL retain data-memory contents through reset.

Configuration
REQ-020 SHALL, with BYTE_ACCESS_EN defined, treat ATypeM=1 as a byte access: a store writes WriteDataM[7:0] to byte address bits [1:0] only; a load returns the addressed byte sign-extended to D_WIDTH.
REQ-021 SHALL, without BYTE_ACCESS_EN, ignore ATypeE/ATypeM and perform every access as a word access.

Structure
REQ-022 SHALL place the ResultSrc encoding (enum: RES_ALU, RES_MEM, RES_PC4) and the AType encoding in the shared pipeline package.
REQ-023 SHALL implement the storage as one sub-module, data_mem, with combinational read and synchronous, byte-maskable write; the pipeline registers and the result mux stay in memory_stage.

Verification
REQ-024 Store: MemWriteE=1, ALUResultE=0x10, WriteDataE=0xDEADBEEF, followed next cycle by a load (ResultSrcE=01, RegWriteE=1, RdE=5) from 0x10. Required: RdW=5, RegWriteW=1 and ResultW=0xDEADBEEF two edges after the load entered.
REQ-025 Forwarding: ALUResultE=0x1234, RegWriteE=1, RdE=7. Required: ALUResultM=0x1234, RdM=7, RegWriteM=1 after one edge; ResultW=0x1234 after two edges.
REQ-026 Flush: store issued with FlushM=1 to 0x20 with data 0x55. Required: RegWriteM=0, and a later load from 0x20 returns the prior contents unchanged.
REQ-027 Reset mid-store: store in M with rst_n=0 at the edge. Required: all outputs 0 and the memory word unchanged; previously written words are still readable after reset.
REQ-028 Byte access (BYTE_ACCESS_EN defined): word 0x11223344 at 0x40; store byte 0x80 to 0x41. Required: a word load returns 0x11228044, and a byte load from 0x41 returns 0xFFFFFF80. Without the macro, the same store writes the full word.
REQ-029 Wrap: store 0xA5 to address DM_DEPTH*4+8. Required: a load from address 8 returns 0xA5; PC+4 path (ResultSrc=10, PCplus4E=0x104) gives ResultW=0x104.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// Shared pipeline encodings for the memory stage: result-source select and access type.
package memory_stage_pkg;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } result_src_e;

   typedef enum logic {
      ACC_WORD = 1'b0,
      ACC_BYTE = 1'b1
   } atype_e;

   localparam int unsigned BYTE_OFF_W = 2;

endpackage

// File: rtl/data_mem.sv
// Word-organised data memory: combinational read, synchronous byte-maskable write.
// Contents have no reset so they survive a pipeline reset.
module data_mem #(
   parameter int D_WIDTH = 32,
   parameter int DEPTH   = 1024,
   localparam int IDX_W  = $clog2(DEPTH),
   localparam int LANES  = D_WIDTH / 8
) (
   input  logic               clk,
   input  logic               we,
   input  logic [LANES-1:0]   be,
   input  logic [IDX_W-1:0]   addr,
   input  logic [D_WIDTH-1:0] wdata,
   output logic [D_WIDTH-1:0] rdata
);

   logic [D_WIDTH-1:0] mem [DEPTH];

   assign rdata = mem[addr];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < LANES; i++) begin
            if (be[i]) begin
               mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: E->M and M->W registers, data memory and writeback mux.
// Optional byte loads/stores are enabled by defining BYTE_ACCESS_EN.
module memory_stage
   import memory_stage_pkg::*;
#(
   parameter int D_WIDTH  = 32,
   parameter int A_WIDTH  = 5,
   parameter int DM_DEPTH = 1024
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               RegWriteE,
   input  logic               MemWriteE,
   input  logic               ATypeE,
   input  logic               FlushM,
   input  logic [1:0]         ResultSrcE,
   input  logic [D_WIDTH-1:0] ALUResultE,
   input  logic [D_WIDTH-1:0] WriteDataE,
   input  logic [D_WIDTH-1:0] PCplus4E,
   input  logic [A_WIDTH-1:0] RdE,
   output logic               RegWriteM,
   output logic [A_WIDTH-1:0] RdM,
   output logic [D_WIDTH-1:0] ALUResultM,
   output logic               RegWriteW,
   output logic [A_WIDTH-1:0] RdW,
   output logic [D_WIDTH-1:0] ResultW
);

   localparam int IDX_W = $clog2(DM_DEPTH);
   localparam int LANES = D_WIDTH / 8;

   logic               reg_write_m, mem_write_m, atype_m;
   logic [1:0]         result_src_m;
   logic [D_WIDTH-1:0] alu_result_m, write_data_m, pc_plus4_m;
   logic [A_WIDTH-1:0] rd_m;

   logic               reg_write_w;
   logic [1:0]         result_src_w;
   logic [D_WIDTH-1:0] alu_result_w, read_data_w, pc_plus4_w;
   logic [A_WIDTH-1:0] rd_w;

   logic               dm_we;
   logic [LANES-1:0]   dm_be;
   logic [D_WIDTH-1:0] dm_wdata, dm_rdata, read_data_m;

   // A flush turns the incoming instruction into a bubble; data fields still load.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         reg_write_m  <= 1'b0;
         mem_write_m  <= 1'b0;
         atype_m      <= 1'b0;
         result_src_m <= 2'b00;
         alu_result_m <= '0;
         write_data_m <= '0;
         pc_plus4_m   <= '0;
         rd_m         <= '0;
      end else begin
         reg_write_m  <= RegWriteE & ~FlushM;
         mem_write_m  <= MemWriteE & ~FlushM;
         atype_m      <= ATypeE;
         result_src_m <= ResultSrcE;
         alu_result_m <= ALUResultE;
         write_data_m <= WriteDataE;
         pc_plus4_m   <= PCplus4E;
         rd_m         <= RdE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         reg_write_w  <= 1'b0;
         result_src_w <= 2'b00;
         alu_result_w <= '0;
         read_data_w  <= '0;
         pc_plus4_w   <= '0;
         rd_w         <= '0;
      end else begin
         reg_write_w  <= reg_write_m;
         result_src_w <= result_src_m;
         alu_result_w <= alu_result_m;
         read_data_w  <= read_data_m;
         pc_plus4_w   <= pc_plus4_m;
         rd_w         <= rd_m;
      end
   end

   // A store still sitting in M when reset is asserted must not reach memory.
   assign dm_we = mem_write_m & rst_n;

`ifdef BYTE_ACCESS_EN
   logic [BYTE_OFF_W-1:0] byte_off;
   logic [7:0]            byte_sel;
   assign byte_off = alu_result_m[BYTE_OFF_W-1:0];
   assign byte_sel = dm_rdata[8*byte_off +: 8];
`else
   logic unused_atype;
   assign unused_atype = atype_m;
`endif

   always_comb begin
      dm_be       = '1;
      dm_wdata    = write_data_m;
      read_data_m = dm_rdata;
`ifdef BYTE_ACCESS_EN
      if (atype_m == ACC_BYTE) begin
         dm_be           = '0;
         dm_be[byte_off] = 1'b1;
         dm_wdata        = {LANES{write_data_m[7:0]}};
         read_data_m     = {{(D_WIDTH-8){byte_sel[7]}}, byte_sel};
      end
`endif
   end

   data_mem #(
      .D_WIDTH (D_WIDTH),
      .DEPTH   (DM_DEPTH)
   ) u_data_mem (
      .clk   (clk),
      .we    (dm_we),
      .be    (dm_be),
      .addr  (alu_result_m[IDX_W+1:2]),
      .wdata (dm_wdata),
      .rdata (dm_rdata)
   );

   always_comb begin
      ResultW = '0;
      case (result_src_w)
         RES_ALU: ResultW = alu_result_w;
         RES_MEM: ResultW = read_data_w;
         RES_PC4: ResultW = pc_plus4_w;
         default: ResultW = '0;
      endcase
   end

   assign RegWriteM  = reg_write_m;
   assign RdM        = rd_m;
   assign ALUResultM = alu_result_m;
   assign RegWriteW  = reg_write_w;
   assign RdW        = rd_w;

endmodule
